// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// The signed-mode feature is selected with the SAR_SEARCH_SIGNED_EN macro.
package sar_search_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam int SAR_WIDTH = 8;
    localparam int SAR_IDX_W = $clog2(SAR_WIDTH);

    // Bit-index width for an arbitrary operand width (never narrower than 1).
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Control and comparator-loop signals of sar_search.
// The master side is the search controller; the slave side is the host plus comparator.
interface sar_search_if
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) ();

    logic             start;
    logic             mode;
    logic             agtb;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done_tick;
    logic [WIDTH-1:0] result;

    modport master (
        input  start,
        input  mode,
        input  agtb,
        output trial,
        output busy,
        output done_tick,
        output result
    );

    modport slave (
        output start,
        output mode,
        output agtb,
        input  trial,
        input  busy,
        input  done_tick,
        input  result
    );

endinterface

// File: rtl/sar_trial_gen.sv
// Combinational trial-word generator: candidate with all bits below k set, MSB-flipped in
// signed mode, plus the matching un-flip of the final candidate (SAR_SEARCH_SIGNED_EN).
module sar_trial_gen
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] cand,
    input  logic [IW-1:0]    k,
    input  logic             mode_q,
    input  logic [WIDTH-1:0] cand_nxt,
    output logic [WIDTH-1:0] bit_k,
    output logic [WIDTH-1:0] trial_word,
    output logic [WIDTH-1:0] res_word
);

    logic [WIDTH-1:0] lo_mask;

    always_comb begin
        bit_k   = WIDTH'(1) << k;
        lo_mask = bit_k - WIDTH'(1);
    end

`ifdef SAR_SEARCH_SIGNED_EN
    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    logic [WIDTH-1:0] flip;

    assign flip       = mode_q ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    assign trial_word = (cand | lo_mask) ^ flip;
    assign res_word   = cand_nxt ^ flip;
`else
    logic unused_mode;

    assign unused_mode = mode_q;
    assign trial_word  = cand | lo_mask;
    assign res_word    = cand_nxt;
`endif

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search around an external a > b comparator, one bit per cycle,
// MSB first. Signed (two's complement) mode exists only with SAR_SEARCH_SIGNED_EN defined.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; trial driven to 0
//   SEARCH | testing bit k of the candidate; agtb resolves it each edge
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    sar_search_if.master bus
);

    localparam int IW = idx_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nxt;
    logic [WIDTH-1:0] cand_set;
    logic [IW-1:0]    k;
    logic [IW-1:0]    k_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             done_q;
    logic             done_nxt;
    logic [WIDTH-1:0] bit_k;
    logic [WIDTH-1:0] trial_word;
    logic [WIDTH-1:0] res_word;

    sar_trial_gen #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_trial_gen (
        .cand       (cand),
        .k          (k),
        .mode_q     (mode_q),
        .cand_nxt   (cand_set),
        .bit_k      (bit_k),
        .trial_word (trial_word),
        .res_word   (res_word)
    );

    // Candidate with the current bit resolved; on the last bit this is the final answer.
    assign cand_set = bus.agtb ? (cand | bit_k) : cand;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cand   <= '0;
            k      <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cand   <= cand_nxt;
            k      <= k_nxt;
            res_q  <= res_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        k_nxt     = k;
        res_nxt   = res_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SEARCH;
                    cand_nxt  = '0;
                    k_nxt     = IW'(WIDTH - 1);
                end
            end
            SEARCH: begin
                cand_nxt = cand_set;
                k_nxt    = k - IW'(1);
                if (k == '0) begin
                    state_nxt = IDLE;
                    res_nxt   = res_word;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SAR_SEARCH_SIGNED_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            mode_q <= bus.mode;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign mode_q      = 1'b0;
`endif

    assign bus.trial     = (state == SEARCH) ? trial_word : '0;
    assign bus.busy      = (state == SEARCH);
    assign bus.done_tick = done_q;
    assign bus.result    = res_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural a > b comparator closes the loop, the
// stimulus pushes expected trials/results, and a negedge monitor pops and compares.
module tb_sar_search;

    localparam int W = 8;
    localparam logic [W-1:0] MSB = 8'h80;
`ifdef SAR_SEARCH_SIGNED_EN
    localparam bit SGN_BUILD = 1'b1;
`else
    localparam bit SGN_BUILD = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sar_search_if #(.WIDTH(W)) bus ();

    sar_search #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [W-1:0] a_val;
    logic         cmp_sgn;

    // Team magnitude comparator: a > b, signed or unsigned.
    assign bus.agtb = cmp_sgn ? ($signed(a_val) > $signed(bus.trial)) : (a_val > bus.trial);

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_run = 0;

    exp_t         exp_q[$];
    logic [W-1:0] trial_q[$];
    exp_t         mon_e;
    logic [W-1:0] mon_t;

    logic [W-1:0] a5_tab [8] = '{8'h7F, 8'hBF, 8'h9F, 8'hAF, 8'hA7, 8'hA3, 8'hA5, 8'hA4};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic bit sgn_eff(input bit m);
        return SGN_BUILD && m;
    endfunction

    // Trial at step i: after i steps the candidate holds the top i bits of the (offset) value,
    // so the trial is that prefix, a 0 at bit k and ones below it.
    function automatic logic [W-1:0] exp_trial(input logic [W-1:0] a, input bit sgn, input int i);
        int           k;
        logic [W-1:0] t;
        logic [W-1:0] pre;
        logic [W-1:0] lo;
        k   = W - 1 - i;
        t   = sgn ? (a ^ MSB) : a;
        pre = (k + 1 >= W) ? '0 : ((t >> (k + 1)) << (k + 1));
        lo  = W'((1 << k) - 1);
        return (pre | lo) ^ (sgn ? MSB : '0);
    endfunction

    task automatic push_exp(input logic [W-1:0] a, input bit m, input int acc, input bit use_tab);
        exp_t e;
        e.res = a;
        e.acc = acc;
        exp_q.push_back(e);
        for (int i = 0; i < W; i++) begin
            trial_q.push_back(use_tab ? a5_tab[i] : exp_trial(a, sgn_eff(m), i));
        end
    endtask

    // Called just after a posedge while IDLE; returns just after the accepting edge (cycle 1).
    task automatic issue(input logic [W-1:0] a, input bit m, input bit use_tab);
        a_val     = a;
        bus.mode  = m;
        cmp_sgn   = sgn_eff(m);
        push_exp(a, m, cyc + 1, use_tab);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) fail_now("done_tick timeout");
    endtask

    task automatic run_one(input logic [W-1:0] a, input bit m);
        int base;
        base = done_cnt;
        issue(a, m, 1'b0);
        wait_done(base + 1);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_run = 0;
        end else begin
            if (bus.busy) begin
                busy_run++;
                if (trial_q.size() == 0) begin
                    fail_now("unexpected busy cycle");
                end else begin
                    mon_t = trial_q.pop_front();
                    chk("trial", 32'(bus.trial), 32'(mon_t));
                end
            end
            if (bus.done_tick) begin
                done_cnt++;
                chk("busy cycles", 32'(busy_run), 32'(W));
                busy_run = 0;
                chk("trial idle", 32'(bus.trial), 32'h0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected done_tick");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 32'(bus.result), 32'(mon_e.res));
                    chk("done cycle", 32'(cyc - mon_e.acc + 1), 32'(W + 1));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        a_val     = '0;
        cmp_sgn   = 1'b0;
        #12;
        chk("reset trial", 32'(bus.trial), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset done", 32'(bus.done_tick), 32'h0);
        chk("reset result", 32'(bus.result), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reference trial sequence for 0xA5.
        base = done_cnt;
        issue(8'hA5, 1'b0, 1'b1);
        wait_done(base + 1);
        #1;

        run_one(8'h00, 1'b0);
        run_one(8'hFF, 1'b0);
        run_one(8'h80, 1'b1);
        run_one(8'h7F, 1'b1);
        run_one(8'hFE, 1'b1);
        run_one(8'h01, 1'b1);

        // start/mode activity during the search must be ignored.
        base = done_cnt;
        issue(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'($urandom);
            bus.mode  = 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        wait_done(base + 1);
        repeat (12) @(posedge clk);
        chk("single done", 32'(done_cnt - base), 32'h1);
        #1;

        // Asynchronous reset in cycle 4 aborts the search.
        issue(8'h6B, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort trial", 32'(bus.trial), 32'h0);
        chk("abort busy", 32'(bus.busy), 32'h0);
        chk("abort done", 32'(bus.done_tick), 32'h0);
        chk("abort result", 32'(bus.result), 32'h0);
        exp_q.delete();
        trial_q.delete();
        base = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("no done after abort", 32'(done_cnt - base), 32'h0);
        #1;
        run_one(8'h11, 1'b0);

        // start held high: back-to-back searches every W+1 cycles.
        base      = done_cnt;
        a_val     = 8'h5A;
        bus.mode  = 1'b0;
        cmp_sgn   = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(8'h5A, 1'b0, cyc + 1 + i * (W + 1), 1'b0);
        bus.start = 1'b1;
        wait_done(base + 2);
        #1;
        bus.start = 1'b0;
        wait_done(base + 3);
        repeat (12) @(posedge clk);
        chk("held-start dones", 32'(done_cnt - base), 32'h3);
        #1;

        for (int i = 0; i < 24; i++) begin
            run_one(8'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        chk("results left", 32'(exp_q.size()), 32'h0);
        chk("trials left", 32'(trial_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
